// File: rtl/uart_echo_if.sv
// Signal bundle between the echo scheduler and its environment
// (UART receiver on one side, UART transmitter on the other).
interface uart_echo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshake rules:
  // - rx_data_valid is a one-cycle strobe with no backpressure; rx_data is valid with it.
  // - tx_en is a one-cycle launch pulse; tx_data is valid from tx_en until the next launch.
  // - The transmitter acknowledges by raising tx_busy and holding it for the whole frame.
  logic                 rx_data_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 cfg_bypass;
  logic                 tx_busy;
  logic                 overflow_clr;
  logic                 tx_en;
  logic [DATA_BITS-1:0] tx_data;
  logic [CW-1:0]        fifo_count;
  logic                 overflow;
  logic                 ack_err;
  logic [1:0]           state_dbg;

  modport master (
    input  rx_data_valid, rx_data, cfg_bypass, tx_busy, overflow_clr,
    output tx_en, tx_data, fifo_count, overflow, ack_err, state_dbg
  );

  modport slave (
    output rx_data_valid, rx_data, cfg_bypass, tx_busy, overflow_clr,
    input  tx_en, tx_data, fifo_count, overflow, ack_err, state_dbg
  );
endinterface

// File: rtl/uart_echo_scheduler.sv
// Buffers received bytes, optionally increments them, and launches them one at a
// time into the UART transmitter with a busy-based acknowledge and timeout.
module uart_echo_scheduler #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst_n,
  uart_echo_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0]        FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0]        PTR_ONE    = PW'(1);
  localparam logic [TW-1:0]        TIMER_ONE  = TW'(1);
  // The timer increments on the edge that sees it equal to TIMER_LAST, which is
  // the edge where it "reaches" ACK_TIMEOUT-1.
  localparam logic [TW-1:0]        TIMER_LAST = TW'(ACK_TIMEOUT - 2);
  localparam logic [DATA_BITS-1:0] DATA_ONE   = DATA_BITS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [TW-1:0]        timer;
  logic                 launch, timeout, full, push_ok, drop;
  logic [DATA_BITS-1:0] head;
  logic                 tx_en_q, overflow_q, ack_err_q;
  logic [DATA_BITS-1:0] tx_data_q;

  assign full    = (count == FULL_COUNT);
  assign push_ok = bus.rx_data_valid && (!full || launch);
  assign drop    = bus.rx_data_valid && full && !launch;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && !bus.tx_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage carries no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      timer      <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      ack_err_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tx_en_q   <= launch;
      ack_err_q <= timeout;
      if (launch) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        tx_data_q <= bus.cfg_bypass ? head : head + DATA_ONE;
        timer     <= '0;
      end else if (state == WAIT_ACK && !bus.tx_busy) begin
        timer <= timeout ? '0 : timer + TIMER_ONE;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push_ok, launch})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                  overflow_q <= 1'b1;
      else if (bus.overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign bus.tx_en      = tx_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;
  assign bus.ack_err    = ack_err_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_uart_echo_scheduler.sv
// Self-checking bench: queue-level reference model of the echo scheduler, a
// reactive transmitter model, directed scenarios and a randomized soak.
module tb_uart_echo_scheduler;
  localparam int DATA_BITS   = 8;
  localparam int FIFO_DEPTH  = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_echo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_echo_scheduler #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: accepted bytes, one frame in flight, sticky overflow.
  logic [DATA_BITS-1:0] exp_q[$];
  logic [DATA_BITS-1:0] m_q[$];
  bit                   m_inflight, m_acked, m_ovf, m_launch, m_ackerr;
  int                   m_wait;
  logic [DATA_BITS-1:0] m_last_tx;

  // Transmitter model.
  bit tx_auto;
  int busy_delay, busy_len, busy_left, pend, mute_pct;

  function automatic logic [DATA_BITS-1:0] xform(logic [DATA_BITS-1:0] b, logic byp);
    logic [DATA_BITS-1:0] r;
    r = byp ? b : b + 8'd1;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_q.delete();
    m_inflight = 0; m_acked = 0; m_ovf = 0; m_launch = 0; m_ackerr = 0;
    m_wait = 0; m_last_tx = '0;
    bus.tx_busy = 1'b0; busy_left = 0; pend = 0;
  endtask

  // Predict the coming edge from the current inputs, clock it, compare.
  task automatic tick();
    bit drop;
    logic [DATA_BITS-1:0] e;
    drop = 0;
    m_ackerr = 0;
    m_launch = !m_inflight && (m_q.size() != 0) && !bus.tx_busy;
    if (m_launch) begin
      m_last_tx = xform(m_q.pop_front(), bus.cfg_bypass);
      exp_q.push_back(m_last_tx);
      m_inflight = 1; m_acked = 0; m_wait = 0;
    end else if (m_inflight) begin
      if (!m_acked) begin
        if (bus.tx_busy) m_acked = 1;
        else begin
          m_wait++;
          if (m_wait == ACK_TIMEOUT - 1) begin m_ackerr = 1; m_inflight = 0; end
        end
      end else if (!bus.tx_busy) m_inflight = 0;
    end
    if (bus.rx_data_valid) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(bus.rx_data);
      else drop = 1;
    end
    if (bus.overflow_clr) m_ovf = 0;
    if (drop) m_ovf = 1;

    @(posedge clk); #1;
    cycle++;

    checks++;
    if (bus.tx_en !== m_launch) begin
      errors++; $display("FAIL tx_en @%0d: got %b expected %b", cycle, bus.tx_en, m_launch);
    end
    if (bus.tx_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL tx_unexpected @%0d: got launch of %0h expected none", cycle, bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          errors++; $display("FAIL tx_data_launch @%0d: got %0h expected %0h", cycle, bus.tx_data, e);
        end
      end
    end else if (m_launch) void'(exp_q.pop_front());
    checks++;
    if (bus.tx_data !== m_last_tx) begin
      errors++; $display("FAIL tx_data_hold @%0d: got %0h expected %0h", cycle, bus.tx_data, m_last_tx);
    end
    checks++;
    if (bus.fifo_count !== CW'(m_q.size())) begin
      errors++; $display("FAIL fifo_count @%0d: got %0d expected %0d", cycle, bus.fifo_count, m_q.size());
    end
    checks++;
    if (bus.overflow !== m_ovf) begin
      errors++; $display("FAIL overflow @%0d: got %b expected %b", cycle, bus.overflow, m_ovf);
    end
    checks++;
    if (bus.ack_err !== m_ackerr) begin
      errors++; $display("FAIL ack_err @%0d: got %b expected %b", cycle, bus.ack_err, m_ackerr);
    end

    bus.rx_data_valid = 1'b0;
    bus.overflow_clr  = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus.tx_busy = 1'b0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin bus.tx_busy = 1'b1; busy_left = busy_len; end
    end
    if (tx_auto && bus.tx_en === 1'b1 && $urandom_range(99) >= mute_pct) begin
      if (busy_delay == 0) begin bus.tx_busy = 1'b1; busy_left = busy_len; end
      else pend = busy_delay;
    end
  endtask

  task automatic push(input logic [DATA_BITS-1:0] b);
    bus.rx_data_valid = 1'b1;
    bus.rx_data       = b;
    tick();
  endtask

  task automatic drain(input int budget, output int n_tx);
    int i;
    n_tx = 0;
    for (i = 0; i < budget; i++) begin
      if (!m_inflight && m_q.size() == 0 && !bus.tx_busy && pend == 0) break;
      tick();
      if (bus.tx_en === 1'b1) n_tx++;
    end
    checks++;
    if (i == budget) begin
      errors++; $display("FAIL drain_timeout: got %0d queued expected 0 within %0d cycles", m_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.tx_en, bus.tx_data, bus.fifo_count, bus.overflow, bus.ack_err} !== '0) begin
      errors++; $display("FAIL reset_values: got en=%b data=%0h cnt=%0d ovf=%b err=%b expected all 0",
        bus.tx_en, bus.tx_data, bus.fifo_count, bus.overflow, bus.ack_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    bus.cfg_bypass = 1'b0;
    tx_auto = 1; busy_delay = 1; busy_len = 10; mute_pct = 0;
    push(8'h41);
    checks++;
    if (bus.tx_en !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", bus.tx_en); end
    tick();
    checks++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h42) begin
      errors++; $display("FAIL single_launch: got en=%b data=%0h expected en=1 data=42", bus.tx_en, bus.tx_data);
    end
    drain(100, n);
    checks++;
    if (bus.fifo_count !== '0) begin errors++; $display("FAIL single_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_wrap();
    int n;
    for (int byp = 0; byp < 2; byp++) begin
      bus.cfg_bypass = byp[0];
      push(8'hFF);
      tick();
      checks++;
      if (bus.tx_en !== 1'b1 || bus.tx_data !== (byp == 1 ? 8'hFF : 8'h00)) begin
        errors++; $display("FAIL wrap_bypass%0d: got en=%b data=%0h expected en=1 data=%0h",
          byp, bus.tx_en, bus.tx_data, (byp == 1 ? 8'hFF : 8'h00));
      end
      drain(100, n);
    end
    bus.cfg_bypass = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int peak = 0, fall = -1, n;
    bit prev_busy;
    tx_auto = 1; busy_delay = 1; busy_len = 20;
    for (int i = 0; i < 200; i++) begin
      if (i < 5) begin bus.rx_data_valid = 1'b1; bus.rx_data = 8'(i + 1); end
      else if (!m_inflight && m_q.size() == 0 && !bus.tx_busy && pend == 0) break;
      prev_busy = bus.tx_busy;
      tick();
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      if (bus.tx_en === 1'b1) begin
        got.push_back(bus.tx_data);
        if (fall >= 0) begin
          checks++;
          if (cycle - fall < 1) begin errors++; $display("FAIL b2b_gap: got %0d expected >=1", cycle - fall); end
        end
      end
      if (prev_busy && !bus.tx_busy) fall = cycle;
    end
    checks++;
    if (peak != 4) begin errors++; $display("FAIL b2b_peak: got %0d expected 4", peak); end
    checks++;
    if (got.size() != 5) begin errors++; $display("FAIL b2b_pulses: got %0d expected 5", got.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 8'(i + 2)) begin errors++; $display("FAIL b2b_order[%0d]: got %0h expected %0h", i, got[i], i + 2); end
      end
    end
    drain(50, n);
  endtask

  task automatic test_overflow();
    int n;
    tx_auto = 0; bus.tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) push(8'($urandom_range(255)));
    checks++;
    if (bus.fifo_count !== CW'(8) || bus.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_full: got cnt=%0d ovf=%b expected cnt=8 ovf=1", bus.fifo_count, bus.overflow);
    end
    bus.overflow_clr = 1'b1;
    push(8'h5A);
    checks++;
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", bus.overflow); end
    bus.overflow_clr = 1'b1;
    tick();
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
    bus.tx_busy = 1'b0;
    tx_auto = 1; busy_delay = 1; busy_len = 3;
    push(8'hC3);
    checks++;
    if (bus.tx_en !== 1'b1 || bus.fifo_count !== CW'(8) || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_push_pop_full: got en=%b cnt=%0d ovf=%b expected en=1 cnt=8 ovf=0",
        bus.tx_en, bus.fifo_count, bus.overflow);
    end
    drain(300, n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 8", n); end
  endtask

  task automatic test_timeout();
    int t0, n;
    bit seen;
    tx_auto = 0; bus.tx_busy = 1'b0;
    push(8'h10);
    push(8'h20);
    t0 = cycle;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.ack_err === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cycle - t0 != ACK_TIMEOUT - 1) begin
      errors++; $display("FAIL ack_err_latency: got %0d expected %0d", seen ? cycle - t0 : -1, ACK_TIMEOUT - 1);
    end
    tick();
    checks++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h21) begin
      errors++; $display("FAIL timeout_next_launch: got en=%b data=%0h expected en=1 data=21", bus.tx_en, bus.tx_data);
    end
    drain(40, n);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tx_auto = 1; busy_delay = 1; busy_len = 30;
    for (int i = 0; i < 4; i++) push(8'(8'h80 + i));
    tick();
    checks++;
    if (bus.fifo_count !== CW'(3) || bus.tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got cnt=%0d busy=%b expected cnt=3 busy=1", bus.fifo_count, bus.tx_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.tx_en, bus.tx_data, bus.fifo_count, bus.overflow, bus.ack_err} !== '0) begin
      errors++; $display("FAIL mid_reset_values: got en=%b data=%0h cnt=%0d ovf=%b err=%b expected all 0",
        bus.tx_en, bus.tx_data, bus.fifo_count, bus.overflow, bus.ack_err);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.tx_en === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL mid_no_launch: got %0d pulses expected 0", n); end
    push(8'h33);
    tick();
    checks++;
    if (bus.tx_en !== 1'b1 || bus.tx_data !== 8'h34) begin
      errors++; $display("FAIL mid_relaunch: got en=%b data=%0h expected en=1 data=34", bus.tx_en, bus.tx_data);
    end
    drain(100, n);
  endtask

  task automatic test_random();
    int n;
    tx_auto = 1; mute_pct = 10;
    for (int i = 0; i < 800; i++) begin
      bus.rx_data_valid = ($urandom_range(99) < 30);
      bus.rx_data       = 8'($urandom_range(255));
      bus.cfg_bypass    = $urandom_range(1) == 1;
      bus.overflow_clr  = ($urandom_range(99) < 5);
      busy_len          = $urandom_range(12, 1);
      busy_delay        = $urandom_range(3);
      tick();
    end
    mute_pct = 0;
    drain(500, n);
  endtask

  initial begin
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = '0;
    bus.cfg_bypass    = 1'b0;
    bus.tx_busy       = 1'b0;
    bus.overflow_clr  = 1'b0;
    tx_auto = 0; busy_delay = 1; busy_len = 10; mute_pct = 0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/uart_echo_scheduler.md
Name: uart_echo_scheduler

Overview:
- Controller between the UART receiver and the UART transmitter in the RX/TX echo path.
- Buffers received bytes in an internal FIFO and applies the byte transform: raw, or +1 modulo 2^DATA_BITS.
- Launches one transmitter request at a time and runs a busy-based handshake with the transmitter, with a timeout.
- Reports FIFO occupancy, sticky overflow and an acknowledge-timeout error.

Parameters:
- DATA_BITS, 8, byte width of the RX/TX data.
- FIFO_DEPTH, 8, buffered bytes; power of two, at least 2.
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after a launch; at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_data_valid  in  1  one-cycle strobe: rx_data is valid
- rx_data  in  DATA_BITS  received byte
- cfg_bypass  in  1  1 = send the raw byte, 0 = send byte+1 (wraps)
- tx_busy  in  1  transmitter busy; high for the whole frame
- tx_en  out  1  one-cycle transmit start pulse
- tx_data  out  DATA_BITS  byte to transmit; held stable from tx_en until the next launch
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow
- ack_err  out  1  one-cycle pulse on acknowledge timeout

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. All state updates on the rising clk edge.
- Reset values: tx_en=0, tx_data=0, fifo_count=0, overflow=0, ack_err=0, state=IDLE, FIFO empty, timer=0.
- Reset mid-frame aborts the handshake and discards FIFO contents; no tx_en pulse is issued after reset release until a new byte is pushed.

FIFO:
- Push on rx_data_valid. Pop only on a launch.
- Push while full with no same-cycle pop: byte dropped, overflow set, count unchanged.
- Push and pop in the same cycle while full: accepted, count unchanged, no overflow.
- Push and pop in the same cycle otherwise: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- overflow_clr and a same-cycle overflow event: the set wins.

FSM states: IDLE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If the FIFO is not empty and tx_busy=0: pop the head, tx_data <= cfg_bypass ? head : head+1 (truncated to DATA_BITS, so 0xFF -> 0x00), tx_en <= 1, timer <= 0, go to WAIT_ACK.
  - cfg_bypass is sampled at the launch edge only.
  - If tx_busy=1 in IDLE (foreign transmit in progress), no launch.
- WAIT_ACK:
  - tx_en <= 0, so tx_en is exactly one cycle wide.
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise timer++. When timer reaches ACK_TIMEOUT-1 without tx_busy: ack_err pulses for one cycle, go to IDLE, the byte is lost (not re-queued).
- WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency: rx_data_valid sampled at edge N with the FIFO empty and the transmitter idle gives tx_en high in the cycle after edge N+1.
- Back-to-back launch: at least one cycle after tx_busy falls, because IDLE must sample tx_busy=0.
- Bytes are transmitted in arrival order. rx_data_valid is accepted in every state.

Test Plan:
- Single byte 0x41, cfg_bypass=0, model transmitter busy 1 cycle after tx_en for 10 cycles -> one tx_en pulse two cycles after the strobe, tx_data=0x42, fifo_count returns to 0.
- Byte 0xFF, cfg_bypass=0 -> tx_data=0x00; repeat with cfg_bypass=1 -> tx_data=0xFF.
- Burst 0x01..0x05 on consecutive cycles with the transmitter busy 20 cycles per frame -> fifo_count peaks at 4, five tx_en pulses with tx_data 0x02..0x06 in order, each launch at least 1 cycle after tx_busy falls.
- FIFO_DEPTH=8, hold tx_busy=1, push 9 bytes -> fifo_count=8, overflow=1, 9th byte never sent; overflow_clr -> overflow=0. Also push while full in the launch cycle -> accepted, no overflow.
- tx_busy never rises after a launch -> ack_err pulses exactly ACK_TIMEOUT-1 cycles after the WAIT_ACK entry edge, FSM returns to IDLE, next queued byte launches.
- Assert rst_n low in WAIT_DONE with 3 bytes queued -> all outputs at reset values, no tx_en pulse after release until a new push.
